// File: rtl/bus_initiator.sv
// Synchronous 68000-style bus master: turns single word/byte requests into
// AS/UDS/LDS/WR bus cycles, waits for a synchronized DTACK and reports DONE/ERR.
module bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        MCLK_IN,
    input  logic        RESET_IN,
    input  logic        REQ_IN,
    input  logic        REQ_WR_IN,
    input  logic        REQ_BYTE_IN,
    input  logic [23:0] REQ_ADDR_IN,
    input  logic [15:0] REQ_WDATA_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        AS,
    output logic        WR,
    output logic        UDS,
    output logic        LDS,
    output logic [23:0] ADDR,
    inout  wire  [15:0] DATA,
    input  logic        DTACK_IN,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic [16:0] C_LIMIT = 17'(TIMEOUT_CYCLES);
    localparam bit          C_TO_EN = (TIMEOUT_CYCLES != 0);

    state_t      r_state;
    logic        r_dt_s1;
    logic        r_dts;
    logic [23:0] r_addr;
    logic        r_wr;
    logic        r_byte;
    logic [15:0] r_wdata;
    logic        r_data_oe;
    logic        r_as;
    logic        r_uds;
    logic        r_lds;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_err_flag;
    logic [15:0] r_rdata;
    logic [15:0] r_cnt;

    logic [16:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_addr_err;
    logic [15:0] w_wdata_lanes;
    logic [15:0] w_rd_capture;

    // Client handshake: REQ_IN is a valid strobe looked at only in IDLE; the
    // request is consumed on that edge and BUSY stays high until the DONE/ERR
    // pulse. An odd word address is rejected with ERR and never raises BUSY.

    assign w_cnt_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_timeout     = C_TO_EN && (w_cnt_inc == C_LIMIT);
    assign w_addr_err    = !REQ_BYTE_IN && REQ_ADDR_IN[0];
    assign w_wdata_lanes = REQ_BYTE_IN ? {REQ_WDATA_IN[7:0], REQ_WDATA_IN[7:0]}
                                       : REQ_WDATA_IN;
    assign w_rd_capture  = !r_byte   ? DATA
                         : r_addr[0] ? {8'h00, DATA[7:0]}
                                     : {8'h00, DATA[15:8]};

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            r_dt_s1 <= 1'b0;
            r_dts   <= 1'b0;
        end else begin
            r_dt_s1 <= DTACK_IN;
            r_dts   <= r_dt_s1;
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            r_state    <= ST_IDLE;
            r_addr     <= 24'h000000;
            r_wr       <= 1'b0;
            r_byte     <= 1'b0;
            r_wdata    <= 16'h0000;
            r_data_oe  <= 1'b0;
            r_as       <= 1'b0;
            r_uds      <= 1'b0;
            r_lds      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
            r_rdata    <= 16'h0000;
            r_cnt      <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (REQ_IN) begin
                        if (w_addr_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr     <= REQ_ADDR_IN;
                            r_wr       <= REQ_WR_IN;
                            r_byte     <= REQ_BYTE_IN;
                            r_wdata    <= w_wdata_lanes;
                            r_data_oe  <= REQ_WR_IN;
                            r_busy     <= 1'b1;
                            r_err_flag <= 1'b0;
                            r_state    <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    r_as    <= 1'b1;
                    r_uds   <= !r_byte || !r_addr[0];
                    r_lds   <= !r_byte || r_addr[0];
                    r_cnt   <= 16'h0000;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // DTACK is checked first so it wins over a same-cycle timeout.
                    if (r_dts || w_timeout) begin
                        if (r_dts && !r_wr) begin
                            r_rdata <= w_rd_capture;
                        end
                        r_err_flag <= !r_dts;
                        r_as       <= 1'b0;
                        r_uds      <= 1'b0;
                        r_lds      <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_cnt      <= 16'h0000;
                        r_state    <= ST_RELEASE;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end

                ST_RELEASE: begin
                    // Leave on DTACK negation, or on a second timeout with it still high.
                    if (!r_dts || w_timeout) begin
                        r_done  <= !r_dts && !r_err_flag;
                        r_err   <= r_err_flag || r_dts;
                        r_busy  <= 1'b0;
                        r_addr  <= 24'h000000;
                        r_wr    <= 1'b0;
                        r_state <= ST_FINISH;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign ERR         = r_err;
    assign RDATA       = r_rdata;
    assign AS          = r_as;
    assign WR          = r_wr;
    assign UDS         = r_uds;
    assign LDS         = r_lds;
    assign ADDR        = r_addr;
    assign DATA        = r_data_oe ? r_wdata : 16'hzzzz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: vector table of single transfers plus
// hand-written reset, back-to-back and wait-forever sequences.
module tb_bus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b;
  logic        req_wr, req_byte;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;

  logic        busy_a, done_a, err_a, as_a, wr_a, uds_a, lds_a;
  logic [15:0] rdata_a;
  logic [23:0] addr_a;
  logic [2:0]  state_a;
  wire  [15:0] bus_a;
  logic        dtack_a = 1'b0;
  logic        drv_en_a = 1'b0;
  logic [15:0] drv_val_a = 16'h0000;

  logic        busy_b, done_b, err_b, as_b, wr_b, uds_b, lds_b;
  logic [15:0] rdata_b;
  logic [23:0] addr_b;
  logic [2:0]  state_b;
  wire  [15:0] bus_b;
  logic        dtack_b;
  logic        drv_en_b;
  logic [15:0] drv_val_b;

  assign bus_a = drv_en_a ? drv_val_a : 16'hzzzz;
  assign bus_b = drv_en_b ? drv_val_b : 16'hzzzz;

  bus_initiator #(.TIMEOUT_CYCLES(8)) u_dut_a (
    .MCLK_IN(clk), .RESET_IN(rst), .REQ_IN(req_a), .REQ_WR_IN(req_wr),
    .REQ_BYTE_IN(req_byte), .REQ_ADDR_IN(req_addr), .REQ_WDATA_IN(req_wdata),
    .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .RDATA(rdata_a), .AS(as_a),
    .WR(wr_a), .UDS(uds_a), .LDS(lds_a), .ADDR(addr_a), .DATA(bus_a),
    .DTACK_IN(dtack_a), .o_dbg_state(state_a)
  );

  bus_initiator #(.TIMEOUT_CYCLES(0)) u_dut_b (
    .MCLK_IN(clk), .RESET_IN(rst), .REQ_IN(req_b), .REQ_WR_IN(req_wr),
    .REQ_BYTE_IN(req_byte), .REQ_ADDR_IN(req_addr), .REQ_WDATA_IN(req_wdata),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .RDATA(rdata_b), .AS(as_b),
    .WR(wr_b), .UDS(uds_b), .LDS(lds_b), .ADDR(addr_b), .DATA(bus_b),
    .DTACK_IN(dtack_b), .o_dbg_state(state_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Responder for bus A: raises DTACK after resp_lat sampled AS-high cycles
  // (0 = never), drives read data with it, drops both when AS falls.
  int          resp_lat = 0;
  logic [15:0] resp_data = 16'h0000;
  int          as_cnt = 0;

  always @(negedge clk) begin
    if (as_a) begin
      as_cnt = as_cnt + 1;
      if (resp_lat != 0 && as_cnt == resp_lat) begin
        dtack_a = 1'b1;
        if (!wr_a) begin
          drv_en_a  = 1'b1;
          drv_val_a = resp_data;
        end
      end
    end else begin
      as_cnt   = 0;
      dtack_a  = 1'b0;
      drv_en_a = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_released(input string name, input logic [15:0] v);
    n_cmp++;
    if (!(v === 16'hzzzz || v === 16'h0000)) begin
      n_bad++;
      $display("FAIL %s: bus reads %h expected released", name, v);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        is_byte;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rsp;
    int          exp_width;
    logic        exp_uds;
    logic        exp_lds;
    logic [15:0] exp_bus;
    logic [15:0] exp_rdata;
    int          exp_end;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  // One transfer on bus A; cycle c=0 is the sample right after the accepting edge.
  task automatic run_vec(input int id, input vec_t v);
    int width = 0, first_as = -1, done_n = 0, err_n = 0, end_c = -1;
    logic uds_s = 0, lds_s = 0, wr_s = 0, strobe_bad = 0, bus_bad = 0;
    logic busy_any = 0, busy0 = 0, busy_end = 1;
    logic [23:0] addr_s = 0, addr_end = 24'hFFFFFF;
    logic [15:0] bus0 = 0, bus_end = 16'hFFFF;
    @(negedge clk);
    req_wr = v.wr; req_byte = v.is_byte; req_addr = v.addr; req_wdata = v.wdata;
    resp_lat = v.lat; resp_data = v.rsp;
    req_a = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_a = 1'b0;
        busy0 = busy_a;
        bus0  = bus_a;
      end
      busy_any = busy_any | busy_a;
      if (as_a) begin
        if (width == 0) begin
          first_as = c; uds_s = uds_a; lds_s = lds_a; addr_s = addr_a; wr_s = wr_a;
        end else if (uds_a !== uds_s || lds_a !== lds_s || addr_a !== addr_s) begin
          strobe_bad = 1'b1;
        end
        if (v.wr && bus_a !== v.exp_bus) bus_bad = 1'b1;
        width++;
      end
      if (done_a || err_a) begin
        if (done_a) done_n++;
        if (err_a) err_n++;
        end_c = c; busy_end = busy_a; addr_end = addr_a; bus_end = bus_a;
      end
    end
    check($sformatf("v%0d_as_width", id), width, v.exp_width);
    check($sformatf("v%0d_done_count", id), done_n, v.exp_err ? 0 : 1);
    check($sformatf("v%0d_err_count", id), err_n, v.exp_err ? 1 : 0);
    check($sformatf("v%0d_end_cycle", id), end_c, v.exp_end);
    check($sformatf("v%0d_rdata", id), rdata_a, v.exp_rdata);
    if (v.exp_width != 0) begin
      check($sformatf("v%0d_as_rise_cycle", id), first_as, 1);
      check($sformatf("v%0d_uds", id), uds_s, v.exp_uds);
      check($sformatf("v%0d_lds", id), lds_s, v.exp_lds);
      check($sformatf("v%0d_wr", id), wr_s, v.wr);
      check($sformatf("v%0d_addr", id), addr_s, v.addr);
      check($sformatf("v%0d_strobes_stable", id), strobe_bad, 0);
      check($sformatf("v%0d_busy_setup", id), busy0, 1);
      check($sformatf("v%0d_busy_at_end", id), busy_end, 0);
      check($sformatf("v%0d_addr_at_end", id), addr_end, 0);
    end else begin
      check($sformatf("v%0d_busy_never", id), busy_any, 0);
    end
    if (v.wr) begin
      check($sformatf("v%0d_bus_setup", id), bus0, v.exp_bus);
      check($sformatf("v%0d_bus_during_as", id), bus_bad, 0);
      check_released($sformatf("v%0d_bus_at_end", id), bus_end);
    end
  endtask

  initial begin
    int dn, en, d1, d2, rise_c, fall_c, as_n, bad;
    logic [23:0] addr_rise;
    vec_t rv;

    rst = 1'b1; req_a = 0; req_b = 0; req_wr = 0; req_byte = 0;
    req_addr = 0; req_wdata = 0; dtack_b = 0; drv_en_b = 0; drv_val_b = 0;

    // wr, byte, addr, wdata, lat, rsp, width, uds, lds, bus, rdata, end, err
    vecs[0] = '{1'b0, 1'b0, 24'h000100, 16'h0000, 2, 16'hBEEF, 4, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 8, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'h100001, 16'h335A, 2, 16'h0000, 4, 1'b0, 1'b1, 16'h5A5A, 16'hBEEF, 8, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 24'h100001, 16'h0000, 2, 16'h12A5, 4, 1'b0, 1'b1, 16'h0000, 16'h00A5, 8, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24'h100002, 16'h0000, 1, 16'h12A5, 3, 1'b1, 1'b0, 16'h0000, 16'h0012, 7, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 24'h0ABCDE, 16'hCAFE, 3, 16'h0000, 5, 1'b1, 1'b1, 16'hCAFE, 16'h0012, 9, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 24'h000003, 16'h0000, 2, 16'h9999, 0, 1'b0, 1'b0, 16'h0000, 16'h0012, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 24'h000200, 16'h0000, 0, 16'h0000, 8, 1'b1, 1'b1, 16'h0000, 16'h0012, 10, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 24'h000010, 16'hA7C3, 2, 16'h0000, 4, 1'b1, 1'b0, 16'hC3C3, 16'h0012, 8, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 24'hFFFFFE, 16'h0000, 6, 16'h8001, 8, 1'b1, 1'b1, 16'h0000, 16'h8001, 12, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 24'h000400, 16'h0000, 7, 16'h7777, 8, 1'b1, 1'b1, 16'h0000, 16'h8001, 12, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_as", as_a, 0);
    check("rst_wr", wr_a, 0);
    check("rst_uds_lds", {uds_a, lds_a}, 0);
    check("rst_addr", addr_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_state", state_a, 0);
    check_released("rst_bus", bus_a);
    check("rst_b_as_busy", {as_b, busy_b}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while a write sits in WAIT.
    @(negedge clk);
    req_wr = 1; req_byte = 0; req_addr = 24'h000020; req_wdata = 16'h9C9C;
    resp_lat = 0; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_pre_as", as_a, 1);
    check("midrst_pre_bus", bus_a, 16'h9C9C);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_as", as_a, 0);
    check("midrst_uds_lds", {uds_a, lds_a}, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done_err", {done_a, err_a}, 0);
    check("midrst_state", state_a, 0);
    check("midrst_rdata", rdata_a, 0);
    check_released("midrst_bus", bus_a);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_a || err_a || as_a) bad++;
    end
    check("midrst_quiet_after", bad, 0);
    rv = '{1'b0, 1'b0, 24'h000040, 16'h0000, 1, 16'h5A01, 3, 1'b1, 1'b1, 16'h0000, 16'h5A01, 7, 1'b0};
    run_vec(20, rv);

    // Back-to-back with REQ_IN held high; request fields change during WAIT.
    @(negedge clk);
    req_wr = 0; req_byte = 0; req_addr = 24'h000100; resp_lat = 2; resp_data = 16'h1111;
    req_a = 1'b1;
    dn = 0; d1 = -1; d2 = -1; rise_c = -1; addr_rise = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) begin req_addr = 24'h000200; req_wr = 1'b1; end
      if (c == 3) begin
        check("b2b_addr_held", addr_a, 24'h000100);
        check("b2b_wr_held", wr_a, 0);
      end
      if (c == 5) req_wr = 1'b0;
      if (done_a) begin
        dn++;
        if (dn == 1) begin d1 = c; resp_data = 16'h2222; end
        else d2 = c;
      end
      if (dn >= 1 && c > d1 && busy_a && rise_c < 0) begin
        rise_c = c; addr_rise = addr_a; req_a = 1'b0;
      end
    end
    check("b2b_first_done", d1, 8);
    check("b2b_second_setup", rise_c, 10);
    check("b2b_second_addr", addr_rise, 24'h000200);
    check("b2b_second_done", d2, 18);
    check("b2b_done_count", dn, 2);
    check("b2b_rdata", rdata_a, 16'h2222);

    // Wait-forever instance: DTACK held off 1000 cycles, then raised.
    @(negedge clk);
    req_wr = 0; req_byte = 0; req_addr = 24'h000300;
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    as_n = 0; bad = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (as_b) as_n++;
      if (done_b || err_b) bad++;
    end
    check("inf_as_held", as_n, 1000);
    check("inf_no_end_early", bad, 0);
    dtack_b = 1'b1; drv_en_b = 1'b1; drv_val_b = 16'h4242;
    dn = 0; en = 0; fall_c = -1; d1 = -1;
    for (int c = 1001; c <= 1020; c++) begin
      @(negedge clk);
      if (!as_b && dtack_b) begin
        dtack_b = 1'b0; drv_en_b = 1'b0; fall_c = c;
      end
      if (done_b) begin dn++; d1 = c; end
      if (err_b) en++;
    end
    check("inf_as_fall", fall_c, 1003);
    check("inf_done_cycle", d1, 1006);
    check("inf_done_count", dn, 1);
    check("inf_err_count", en, 0);
    check("inf_rdata", rdata_b, 16'h4242);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Synchronous 68000-style bus master. It turns single-word or single-byte transfer requests from an internal client (loader, debug monitor, memory test engine) into AS/UDS/LDS/WR bus cycles. It waits for DTACK from the bus responder (address decoder / DTACK generator), then returns read data or completion status. It sits on the same bus as the CPU and drives it only while the CPU is held off the bus (RUN negated or an external arbiter grant).

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before abort; 0 = wait forever (needed when the responder is in step mode); counter is 16 bits, legal range 0..65535.

Ports:
- MCLK_IN  input  1  system clock; all logic on rising edge.
- RESET_IN  input  1  synchronous, active-high reset.
- REQ_IN  input  1  transfer request; sampled only in IDLE.
- REQ_WR_IN  input  1  1 = write, 0 = read.
- REQ_BYTE_IN  input  1  1 = byte transfer, 0 = word transfer.
- REQ_ADDR_IN  input  24  byte address.
- REQ_WDATA_IN  input  16  write data; a byte write uses [7:0].
- BUSY  output  1  high from request acceptance until the DONE or ERR pulse.
- DONE  output  1  one-cycle pulse on successful completion.
- ERR  output  1  one-cycle pulse on address error or timeout; DONE is not pulsed.
- RDATA  output  16  read result; a byte read is zero-extended into [7:0].
- AS  output  1  address strobe, active-high.
- WR  output  1  write qualifier, active-high.
- UDS  output  1  upper (even) byte strobe, active-high.
- LDS  output  1  lower (odd) byte strobe, active-high.
- ADDR  output  24  bus address; bit 0 equals REQ_ADDR_IN[0].
- DATA  inout  16  bus data; driven only during write cycles, otherwise Z.
- DTACK_IN  input  1  data acknowledge from the responder, active-high; passes through a 2-flop synchronizer (DTS).

## Operation
- States: IDLE, SETUP, WAIT, RELEASE, FINISH.
- IDLE:
  - REQ_IN=1 with REQ_BYTE_IN=0 and REQ_ADDR_IN[0]=1 is an address error. Pulse ERR the next cycle, start no bus cycle, and stay in IDLE. BUSY stays 0.
  - REQ_IN=1 otherwise: register address, WR, size and data. Go to SETUP. BUSY=1.
- SETUP (1 cycle):
  - ADDR and WR are valid.
  - For a write, DATA is driven with REQ_WDATA_IN for a word. For a byte, {REQ_WDATA_IN[7:0], REQ_WDATA_IN[7:0]} is driven on both lanes.
  - AS, UDS and LDS stay 0. Next state is WAIT.
- WAIT:
  - AS=1.
  - Word transfer: UDS=LDS=1.
  - Byte transfer: UDS=~ADDR[0] and LDS=ADDR[0].
  - The timeout counter increments every cycle.
  - DTS=1: for a read, capture DATA into RDATA. A word takes DATA[15:0]. A byte takes DATA[15:8] when the address is even and DATA[7:0] when it is odd, with the upper byte cleared. Go to RELEASE.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with DTS still 0: set the error flag and go to RELEASE.
  - DTS=1 and timeout on the same cycle: DTACK wins and the transfer completes normally.
- RELEASE:
  - AS, UDS and LDS are 0 and DATA is Z, registered on the WAIT→RELEASE edge.
  - ADDR and WR hold their values.
  - Wait for DTS=0; the timeout counter restarts and the same limit applies.
  - On DTS=0 go to FINISH.
  - A timeout here also sets the error flag and goes to FINISH.
- FINISH (1 cycle): pulse DONE, or ERR if the error flag is set. BUSY=0 and ADDR/WR return to 0. Go to IDLE.
- A new request can be accepted on the cycle after FINISH.
- REQ_IN is ignored whenever the state is not IDLE.
- RDATA changes only on a successful read capture. It holds across writes and errors.
- A timed-out read leaves RDATA unchanged.

## Timing
- Reset: while RESET_IN=1, every output register takes its reset value at each edge.
  - Reset values: AS=WR=UDS=LDS=0, ADDR=0, DATA=Z, BUSY=DONE=ERR=0, RDATA=0, synchronizer=0, state=IDLE.
  - A reset in the middle of a cycle negates AS and the strobes and releases DATA on the next edge. No DONE or ERR is emitted.
- Request sampled at edge E0: SETUP during E0..E1; AS and strobes rise at E1.
- DTACK_IN rising before edge Ek: DTS=1 after Ek+1; AS falls at Ek+2. Read data is sampled at Ek+2.
- DTACK_IN falling before edge Em: FINISH entered at Em+2; DONE high for the cycle Em+2..Em+3.
- Minimum AS width: 3 cycles, with DTACK_IN already high at E1.
- Timeout with TIMEOUT_CYCLES=N: AS is high for exactly N cycles, then falls. ERR pulses once DTS=0 is seen, or after a further N cycles.
- DATA output enable changes only on state edges and never overlaps an AS=0, WR=0 interval.

## Test plan
- Word read at 0x000100: responder model raises DTACK_IN 2 cycles after AS, data 0xBEEF, drops DTACK when AS falls.
  - Required: UDS=LDS=1, WR=0, AS width 4 cycles, RDATA=0xBEEF, one DONE pulse, BUSY low with DONE.
- Byte write of 0x5A to odd address 0x100001.
  - Required: DATA=0x5A5A during SETUP..WAIT, LDS=1, UDS=0, WR=1.
  - Then a byte read of the same address with the responder returning 0x12A5 gives RDATA=0x00A5.
- Word request with REQ_ADDR_IN=0x000003.
  - Required: AS never asserts, ERR pulses 1 cycle after the request, BUSY stays 0.
- TIMEOUT_CYCLES=8 with DTACK_IN tied 0.
  - Required: AS high exactly 8 cycles, ERR pulse, no DONE, RDATA unchanged.
  - With TIMEOUT_CYCLES=0 and DTACK_IN held off for 1000 cycles then raised: AS stays high throughout, then normal DONE.
- RESET_IN asserted while in WAIT during a write.
  - Required: on the next edge AS=UDS=LDS=0, DATA=Z, BUSY=0, no DONE or ERR.
  - A following request completes normally.
- Back-to-back requests with REQ_IN held high.
  - Required: second SETUP starts the cycle after FINISH.
  - REQ_IN changes during WAIT are ignored.
